// File: rtl/jr_target_unit.sv
// ----------------------------------------------------------------------------
// jr_target_unit
//
// Resolves the target of a register-indirect jump (JR) sitting in ID and
// drives the PC redirect for it. The target is picked from the forwarding
// network with fixed priority. If the source register is still being loaded by
// the instruction in EX, the unit stalls IF/ID for one cycle and inserts a
// bubble. It then takes the loaded value from the MEM load-data path.
//
// Optional feature: define JR_PERF_CNT_EN to build the saturating performance
// counters. When it is undefined, jr_count and jr_stall_count are tied to 0.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   jr_valid          JR instruction present in ID
//   fwd_*             JR source selects (ex > mem > mem_ldata > wb > id)
//   ex_mem_re         instruction in EX is a load
//   *_data            candidate target values (id_rs_data when no fwd_*)
//   ext_stall         hold from the main hazard unit
//   jr_kill           squash of the JR in ID
//   stall_if_id       hold PC and IF/ID (load-use on the JR source)
//   id_ex_bubble      insert NOP into ID/EX (same condition as stall_if_id)
//   pc_redirect       one-cycle PC load pulse
//   pc_target         redirect address; holds the last captured value
//   flush_if_id       squash the fetched instruction (with pc_redirect)
//   busy              state is not IDLE
//   sel_err           sticky: more than one fwd_* seen at a capture
//   jr_count          redirect pulses issued (saturating)
//   jr_stall_count    hazard stall cycles (saturating)
// ----------------------------------------------------------------------------
module jr_target_unit #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jr_valid,
    input  logic              fwd_ex,
    input  logic              fwd_mem,
    input  logic              fwd_mem_ldata,
    input  logic              fwd_wb,
    input  logic              fwd_id,
    input  logic              ex_mem_re,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_ldata,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic              ext_stall,
    input  logic              jr_kill,
    output logic              stall_if_id,
    output logic              id_ex_bubble,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              busy,
    output logic              sel_err,
    output logic [15:0]       jr_count,
    output logic [15:0]       jr_stall_count
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StWaitLoad = 2'd1;
    localparam logic [1:0] StRedirect = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              sel_err_q, sel_err_d;

    logic              load_hazard;
    logic              capture;
    logic              hazard_stall;
    logic [DATA_W-1:0] sel_target;
    logic [2:0]        fwd_cnt;
    logic              multi_sel;
    logic              in_redirect;

    // The JR source is produced by a load still in EX: its data does not
    // exist yet, so the JR must wait one cycle for the MEM load-data path.
    assign load_hazard = jr_valid & fwd_ex & ex_mem_re;

    // Fixed-priority target select. The youngest producer wins.
    always_comb begin
        sel_target = id_rs_data;
        if (fwd_ex) begin
            sel_target = ex_data;
        end else if (fwd_mem) begin
            sel_target = mem_data;
        end else if (fwd_mem_ldata) begin
            sel_target = mem_ldata;
        end else if (fwd_wb) begin
            sel_target = wb_data;
        end else if (fwd_id) begin
            sel_target = id_rs_data;
        end
    end

    // More than one select at once points to a fault in the forwarding
    // controller. The priority mux still gives a defined target.
    assign fwd_cnt = {2'b00, fwd_ex} + {2'b00, fwd_mem} + {2'b00, fwd_mem_ldata}
                   + {2'b00, fwd_wb} + {2'b00, fwd_id};
    assign multi_sel = (fwd_cnt > 3'd1);

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        hazard_stall = 1'b0;

        case (state_q)
            StIdle: begin
                if (jr_valid && !jr_kill && !ext_stall) begin
                    if (load_hazard) begin
                        hazard_stall = 1'b1;
                        state_d      = StWaitLoad;
                    end else begin
                        capture = 1'b1;
                        state_d = StRedirect;
                    end
                end
            end
            StWaitLoad: begin
                // Upstream now reports the load result on fwd_mem_ldata.
                if (!jr_kill && !ext_stall) begin
                    capture = 1'b1;
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A squash always wins and drops any capture in flight.
        if (jr_kill) begin
            state_d = StIdle;
            capture = 1'b0;
        end
    end

    assign target_d  = capture ? sel_target : target_q;
    assign sel_err_d = sel_err_q | (capture & multi_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            target_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Redirect and flush decode from the registered state. A kill or a reset
    // in the same cycle suppresses them.
    assign in_redirect  = (state_q == StRedirect);
    assign pc_redirect  = in_redirect & ~jr_kill & ~rst;
    assign flush_if_id  = in_redirect & ~jr_kill & ~rst;
    assign stall_if_id  = hazard_stall & ~rst;
    assign id_ex_bubble = hazard_stall & ~rst;
    assign busy         = (state_q != StIdle) & ~rst;
    assign pc_target    = target_q;
    assign sel_err      = sel_err_q;

`ifdef JR_PERF_CNT_EN
    logic [15:0] jr_cnt_q, jr_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        jr_cnt_d    = jr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pc_redirect && (jr_cnt_q != 16'hFFFF)) begin
            jr_cnt_d = jr_cnt_q + 16'd1;
        end
        if (stall_if_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jr_cnt_q    <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            jr_cnt_q    <= jr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign jr_count       = jr_cnt_q;
    assign jr_stall_count = stall_cnt_q;
`else
    assign jr_count       = 16'd0;
    assign jr_stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_jr_target_unit.sv
module tb_jr_target_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        jr_valid, fwd_ex, fwd_mem, fwd_mem_ldata, fwd_wb, fwd_id, ex_mem_re;
    logic [15:0] ex_data, mem_data, mem_ldata, wb_data, id_rs_data;
    logic        ext_stall, jr_kill;
    logic        stall_if_id, id_ex_bubble, pc_redirect, flush_if_id, busy, sel_err;
    logic [15:0] pc_target, jr_count, jr_stall_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    jr_target_unit #(.DATA_W(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .jr_valid       (jr_valid),
        .fwd_ex         (fwd_ex),
        .fwd_mem        (fwd_mem),
        .fwd_mem_ldata  (fwd_mem_ldata),
        .fwd_wb         (fwd_wb),
        .fwd_id         (fwd_id),
        .ex_mem_re      (ex_mem_re),
        .ex_data        (ex_data),
        .mem_data       (mem_data),
        .mem_ldata      (mem_ldata),
        .wb_data        (wb_data),
        .id_rs_data     (id_rs_data),
        .ext_stall      (ext_stall),
        .jr_kill        (jr_kill),
        .stall_if_id    (stall_if_id),
        .id_ex_bubble   (id_ex_bubble),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target),
        .flush_if_id    (flush_if_id),
        .busy           (busy),
        .sel_err        (sel_err),
        .jr_count       (jr_count),
        .jr_stall_count (jr_stall_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every redirect pulse must match the oldest expected target.
    always @(negedge clk) begin
        if (!rst && pc_redirect) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_redirect", 32'(pc_target), 32'hFFFF_FFFF);
            end else begin
                check_val("sb_redirect_target", 32'(pc_target), 32'(exp_q.pop_front()));
            end
            check_val("sb_flush_with_redirect", 32'(flush_if_id), 32'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Unselected buses carry distinct junk so a wrong mux leg is visible.
    task automatic clear_inputs();
        jr_valid = 0; fwd_ex = 0; fwd_mem = 0; fwd_mem_ldata = 0; fwd_wb = 0; fwd_id = 0;
        ex_mem_re = 0; ext_stall = 0; jr_kill = 0;
        ex_data = 16'hE0E0; mem_data = 16'hA1A1; mem_ldata = 16'hB2B2;
        wb_data = 16'hC3C3; id_rs_data = 16'hD4D4;
    endtask

    // sel: 0 ex (no load), 1 mem, 2 mem_ldata, 3 wb, 4 id, 5 none
    task automatic drive_sel(input int sel, input logic [15:0] val);
        case (sel)
            0: begin fwd_ex = 1; ex_data = val; end
            1: begin fwd_mem = 1; mem_data = val; end
            2: begin fwd_mem_ldata = 1; mem_ldata = val; end
            3: begin fwd_wb = 1; wb_data = val; end
            4: begin fwd_id = 1; id_rs_data = val; end
            default: id_rs_data = val;
        endcase
    endtask

    task automatic simple_jr(input int sel, input logic [15:0] val);
        clear_inputs();
        drive_sel(sel, val);
        jr_valid = 1;
        exp_q.push_back(val);
        settle();
        check_val("no_stall_plain_jr", 32'(stall_if_id), 32'd0);
        cyc();
        clear_inputs();
        settle();
        check_val("redirect_pulse", 32'(pc_redirect), 32'd1);
        check_val("redirect_target", 32'(pc_target), 32'(val));
        cyc();
        settle();
        check_val("redirect_one_cycle", 32'(pc_redirect), 32'd0);
        check_val("target_held", 32'(pc_target), 32'(val));
    endtask

    task automatic hazard_jr(input logic [15:0] val);
        clear_inputs();
        fwd_ex = 1; ex_mem_re = 1; jr_valid = 1;
        settle();
        check_val("hazard_stall", 32'(stall_if_id), 32'd1);
        check_val("hazard_bubble", 32'(id_ex_bubble), 32'd1);
        cyc();
        clear_inputs();
        fwd_mem_ldata = 1; mem_ldata = val; jr_valid = 1;
        exp_q.push_back(val);
        settle();
        check_val("wait_no_stall", 32'(stall_if_id), 32'd0);
        check_val("wait_no_bubble", 32'(id_ex_bubble), 32'd0);
        check_val("wait_busy", 32'(busy), 32'd1);
        check_val("wait_no_redirect", 32'(pc_redirect), 32'd0);
        cyc();
        clear_inputs();
        settle();
        check_val("hazard_redirect", 32'(pc_redirect), 32'd1);
        check_val("hazard_target", 32'(pc_target), 32'(val));
        cyc();
        settle();
        check_val("hazard_redirect_end", 32'(pc_redirect), 32'd0);
    endtask

    logic [15:0] sweep_vals[6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};

    initial begin
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        settle();
        check_val("rst_redirect", 32'(pc_redirect), 32'd0);
        check_val("rst_flush", 32'(flush_if_id), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_target", 32'(pc_target), 32'd0);
        check_val("rst_sel_err", 32'(sel_err), 32'd0);
        check_val("rst_jr_count", 32'(jr_count), 32'd0);
        check_val("rst_stall_count", 32'(jr_stall_count), 32'd0);
        rst = 0;

        // Basic WB-forwarded JR
        simple_jr(3, 16'h0040);

        // Load-use hazard on the JR source
        hazard_jr(16'h1234);

        // One select at a time, plus the no-select default
        for (int i = 0; i < 6; i++) begin
            simple_jr(i, sweep_vals[i]);
        end
        check_val("sel_err_clean", 32'(sel_err), 32'd0);

        // Conflicting selects: priority picks EX, error is sticky
        clear_inputs();
        fwd_ex = 1; fwd_wb = 1; ex_data = 16'h0010; wb_data = 16'h0020; jr_valid = 1;
        exp_q.push_back(16'h0010);
        cyc();
        clear_inputs();
        settle();
        check_val("prio_target", 32'(pc_target), 32'h0010);
        check_val("sel_err_set", 32'(sel_err), 32'd1);
        cyc();
        cyc();
        check_val("sel_err_sticky", 32'(sel_err), 32'd1);

        // Kill while waiting on the load
        clear_inputs();
        fwd_ex = 1; ex_mem_re = 1; jr_valid = 1;
        cyc();
        clear_inputs();
        jr_kill = 1; fwd_mem_ldata = 1; mem_ldata = 16'hBEEF; jr_valid = 1;
        settle();
        check_val("kill_wait_no_redirect", 32'(pc_redirect), 32'd0);
        cyc();
        clear_inputs();
        settle();
        check_val("kill_wait_idle", 32'(busy), 32'd0);
        check_val("kill_wait_no_pulse", 32'(pc_redirect), 32'd0);
        check_val("kill_wait_target_kept", 32'(pc_target), 32'h0010);
        cyc();

        // External stall held for 3 cycles in WAIT_LOAD
        clear_inputs();
        fwd_ex = 1; ex_mem_re = 1; jr_valid = 1;
        cyc();
        clear_inputs();
        ext_stall = 1; fwd_mem_ldata = 1; mem_ldata = 16'h5678; jr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_val("ext_stall_busy", 32'(busy), 32'd1);
            check_val("ext_stall_no_redirect", 32'(pc_redirect), 32'd0);
            cyc();
        end
        ext_stall = 0;
        exp_q.push_back(16'h5678);
        cyc();
        clear_inputs();
        settle();
        check_val("ext_stall_release_redirect", 32'(pc_redirect), 32'd1);
        check_val("ext_stall_release_target", 32'(pc_target), 32'h5678);
        cyc();

        // External stall in IDLE blocks everything
        clear_inputs();
        fwd_ex = 1; ex_mem_re = 1; jr_valid = 1; ext_stall = 1;
        settle();
        check_val("idle_ext_stall_no_stall", 32'(stall_if_id), 32'd0);
        cyc();
        clear_inputs();
        settle();
        check_val("idle_ext_stall_idle", 32'(busy), 32'd0);
        check_val("idle_ext_stall_no_redirect", 32'(pc_redirect), 32'd0);

        // Kill in REDIRECT suppresses the pulse
        clear_inputs();
        fwd_wb = 1; wb_data = 16'h0700; jr_valid = 1;
        cyc();
        clear_inputs();
        jr_kill = 1;
        settle();
        check_val("kill_redirect_no_pulse", 32'(pc_redirect), 32'd0);
        check_val("kill_redirect_no_flush", 32'(flush_if_id), 32'd0);
        cyc();
        clear_inputs();
        settle();
        check_val("kill_redirect_idle", 32'(busy), 32'd0);

        // Reset on a capture cycle
        clear_inputs();
        fwd_wb = 1; wb_data = 16'h0800; jr_valid = 1; rst = 1;
        cyc();
        rst = 0;
        clear_inputs();
        settle();
        check_val("rst_capture_no_redirect", 32'(pc_redirect), 32'd0);
        check_val("rst_capture_no_flush", 32'(flush_if_id), 32'd0);
        check_val("rst_capture_busy", 32'(busy), 32'd0);
        check_val("rst_capture_target", 32'(pc_target), 32'd0);
        check_val("rst_capture_sel_err", 32'(sel_err), 32'd0);

        // Reset while waiting on the load
        clear_inputs();
        fwd_ex = 1; ex_mem_re = 1; jr_valid = 1;
        cyc();
        clear_inputs();
        fwd_mem_ldata = 1; mem_ldata = 16'h0900; jr_valid = 1; rst = 1;
        cyc();
        rst = 0;
        clear_inputs();
        settle();
        check_val("rst_wait_busy", 32'(busy), 32'd0);
        check_val("rst_wait_no_redirect", 32'(pc_redirect), 32'd0);
        cyc();
        settle();
        check_val("rst_wait_still_quiet", 32'(pc_redirect), 32'd0);

        // Three JRs, one with a hazard, from a clean reset
        rst = 1;
        cyc();
        rst = 0;
        simple_jr(3, 16'h0A00);
        hazard_jr(16'h0B00);
        simple_jr(4, 16'h0C00);
`ifdef JR_PERF_CNT_EN
        check_val("perf_jr_count", 32'(jr_count), 32'd3);
        check_val("perf_stall_count", 32'(jr_stall_count), 32'd1);
`else
        check_val("perf_jr_count_off", 32'(jr_count), 32'd0);
        check_val("perf_stall_count_off", 32'(jr_stall_count), 32'd0);
`endif

        cyc();
        cyc();
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jr_target_unit.md
JR_TARGET_UNIT -- requirements
Module: jr_target_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of PC, register data and target.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port jr_valid  input  1  JR instruction present in ID.
REQ-005 SHALL have ports fwd_ex, fwd_mem, fwd_mem_ldata, fwd_wb, fwd_id  input  1 each  JR source selects from the JR forwarding controller.
REQ-006 SHALL have port ex_mem_re  input  1  instruction in EX is a load.
REQ-007 SHALL have ports ex_data, mem_data, mem_ldata, wb_data, id_rs_data  input  DATA_W each  candidate JR target values.
REQ-008 SHALL have ports ext_stall  input  1  hold from main hazard unit; jr_kill  input  1  squash of JR in ID.
REQ-009 SHALL have ports stall_if_id  output  1  hold PC and IF/ID; id_ex_bubble  output  1  insert NOP into ID/EX.
REQ-010 SHALL have ports pc_redirect  output  1  one-cycle PC load pulse; pc_target  output  DATA_W  redirect address.
REQ-011 SHALL have ports flush_if_id  output  1  squash fetched instruction; busy  output  1  state != IDLE; sel_err  output  1  sticky select fault.
REQ-012 SHALL have ports jr_count, jr_stall_count  output  16 each  performance counters.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_LOAD, REDIRECT.
REQ-014 SHALL define load hazard as jr_valid & fwd_ex & ex_mem_re.
REQ-015 SHALL select target with priority fwd_ex > fwd_mem > fwd_mem_ldata > fwd_wb > fwd_id; with none asserted, id_rs_data.
REQ-016 IDLE: jr_valid & ~jr_kill & ~ext_stall & ~hazard -> capture target, go REDIRECT.
REQ-017 IDLE: jr_valid & ~jr_kill & ~ext_stall & hazard -> stall_if_id=1 and id_ex_bubble=1 combinationally that cycle, no capture, go WAIT_LOAD.
REQ-018 WAIT_LOAD: ~ext_stall & ~jr_kill -> capture target (upstream now reports fwd_mem_ldata), go REDIRECT; ext_stall -> remain.
REQ-019 REDIRECT: pc_redirect=1 and flush_if_id=1 for exactly one cycle, pc_target=captured value, then IDLE unconditionally.
REQ-020 SHALL make pc_redirect and flush_if_id registered (state-decoded); capture-to-redirect latency exactly 1 cycle; hazard adds exactly 1 cycle.
REQ-021 jr_kill in any state SHALL force IDLE next cycle and suppress pc_redirect/flush_if_id in that cycle.
REQ-022 ext_stall in IDLE SHALL block capture; state stays IDLE; stall_if_id stays 0.
REQ-023 pc_target SHALL hold last captured value outside REDIRECT.
REQ-024 sel_err SHALL set when more than one fwd_* is asserted at a capture; cleared only by reset.
REQ-025 stall_if_id and id_ex_bubble SHALL be 0 in WAIT_LOAD and REDIRECT.

Reset
REQ-026 On rst: state=IDLE, pc_target=0, pc_redirect=0, flush_if_id=0, busy=0, sel_err=0, counters=0, stall_if_id=0, id_ex_bubble=0.
REQ-027 rst mid-WAIT_LOAD or mid-REDIRECT SHALL abort with no redirect pulse in the following cycle.

Configuration
REQ-028 Macro JR_PERF_CNT_EN defined: jr_count increments on each REDIRECT cycle and jr_stall_count on each hazard stall cycle, both saturating at 16'hFFFF.
REQ-029 Macro JR_PERF_CNT_EN undefined: no counter registers; jr_count and jr_stall_count tied to 0.

Verification
REQ-030 fwd_wb=1, wb_data=16'h0040, jr_valid=1 one cycle -> next cycle pc_redirect=1, flush_if_id=1, pc_target=16'h0040; following cycle pc_redirect=0.
REQ-031 fwd_ex=1, ex_mem_re=1, jr_valid -> stall_if_id=1, id_ex_bubble=1 same cycle; next cycle fwd_mem_ldata=1, mem_ldata=16'h1234 -> redirect to 16'h1234 one cycle later.
REQ-032 fwd_ex=1 and fwd_wb=1 with ex_data=16'h0010, wb_data=16'h0020 -> pc_target=16'h0010, sel_err=1 until rst.
REQ-033 Hazard entry then jr_kill=1 in WAIT_LOAD -> IDLE next cycle, no pc_redirect; ext_stall=1 for 3 cycles in WAIT_LOAD -> busy=1 held, redirect after release.
REQ-034 rst asserted during REDIRECT-bound capture -> no pc_redirect pulse, all outputs at reset values; with JR_PERF_CNT_EN, 3 JRs (one with hazard) -> jr_count=3, jr_stall_count=1.
